// File: rtl/nn_pkg.sv
// Shared constants and state encoding for the layer-1/layer-2 post-processing stages.
package nn_pkg;

    localparam int L1_NEURONS = 32;
    localparam int ACC_W      = 20;
    localparam int ACT_W      = 8;
    localparam int QSHIFT     = 8;
    localparam int ACT_MAX    = 127;
    localparam int IDX_W      = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } l1_state_t;

endpackage

// File: rtl/relu_sat_q.sv
// Combinational ReLU + floor right shift + saturation of one signed accumulator.
module relu_sat_q #(
    parameter int IN_W  = 20,
    parameter int OUT_W = 8,
    parameter int SHIFT = 8,
    parameter int MAX   = 127
) (
    input  logic [IN_W-1:0]  i_acc,
    output logic [OUT_W-1:0] o_q
);

    localparam logic [IN_W-1:0] LIMIT = IN_W'(MAX);

    logic [IN_W-1:0] w_shifted;

    // Negative inputs are clamped first, so a logical shift equals the floor shift here.
    assign w_shifted = i_acc >> SHIFT;

    always_comb begin
        o_q = '0;
        if (!i_acc[IN_W-1]) begin
            if (w_shifted > LIMIT) begin
                o_q = LIMIT[OUT_W-1:0];
            end else begin
                o_q = w_shifted[OUT_W-1:0];
            end
        end
    end

endmodule

// File: rtl/relu_quant_l1.sv
// Layer-1 post-processing: snapshot the MAC accumulators on start, then stream
// one ReLU-requantised int8 activation per handshake to layer 2.
module relu_quant_l1
    import nn_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [L1_NEURONS*ACC_W-1:0] acc_in_packed,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [ACT_W-1:0]            out_data,
    output logic [IDX_W-1:0]            out_idx,
    output logic                        out_last,
    output logic                        busy,
    output logic                        done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(L1_NEURONS - 1);

    l1_state_t        r_state;
    l1_state_t        w_nextState;
    logic [ACC_W-1:0] r_snap [L1_NEURONS];
    logic [IDX_W-1:0] r_idx;
    logic [ACT_W-1:0] r_data;
    logic             r_valid;
    logic             r_last;

    logic [IDX_W-1:0] w_nextIdx;
    logic [ACT_W-1:0] w_nextData;
    logic             w_nextValid;
    logic             w_nextLast;
    logic             w_snapEn;
    logic             w_accept;
    logic [IDX_W-1:0] w_qSel;
    logic [ACT_W-1:0] w_q;

    // The MAC array is free to clear once this copy is taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < L1_NEURONS; j++) begin
                r_snap[j] <= '0;
            end
        end else if (w_snapEn) begin
            for (int j = 0; j < L1_NEURONS; j++) begin
                r_snap[j] <= acc_in_packed[j*ACC_W +: ACC_W];
            end
        end
    end

    // One shared quantiser looks ahead at the element that will be presented next.
    assign w_qSel   = (r_state == ST_LOAD) ? '0 : r_idx + IDX_W'(1);
    assign w_accept = r_valid && out_ready;

    relu_sat_q #(
        .IN_W  (ACC_W),
        .OUT_W (ACT_W),
        .SHIFT (QSHIFT),
        .MAX   (ACT_MAX)
    ) u_quant (
        .i_acc (r_snap[w_qSel]),
        .o_q   (w_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_idx   <= w_nextIdx;
            r_data  <= w_nextData;
            r_valid <= w_nextValid;
            r_last  <= w_nextLast;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_nextIdx   = r_idx;
        w_nextData  = r_data;
        w_nextValid = r_valid;
        w_nextLast  = r_last;
        w_snapEn    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_snapEn    = 1'b1;
                    w_nextState = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_nextData  = w_q;
                w_nextIdx   = '0;
                w_nextValid = 1'b1;
                w_nextLast  = (LAST_IDX == '0);
                w_nextState = ST_STREAM;
            end
            ST_STREAM: begin
                if (w_accept) begin
                    if (r_idx == LAST_IDX) begin
                        w_nextValid = 1'b0;
                        w_nextLast  = 1'b0;
                        w_nextState = ST_DONE;
                    end else begin
                        w_nextIdx  = r_idx + IDX_W'(1);
                        w_nextData = w_q;
                        w_nextLast = ((r_idx + IDX_W'(1)) == LAST_IDX);
                    end
                end
            end
            ST_DONE: begin
                w_nextState = ST_IDLE;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_idx   = r_idx;
    assign out_last  = r_last;
    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_DONE);

endmodule

// File: tb/tb_relu_quant_l1.sv
// Directed bench for relu_quant_l1: quantisation sweep, full vector, backpressure,
// snapshot isolation and asynchronous reset mid-stream.
module tb_relu_quant_l1;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [639:0] acc_in_packed = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [7:0]   out_data;
    logic [4:0]   out_idx;
    logic         out_last;
    logic         busy;
    logic         done;

    int testCount = 0;
    int failCount = 0;
    int expData [32];

    relu_quant_l1 dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .acc_in_packed (acc_in_packed),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_idx       (out_idx),
        .out_last      (out_last),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        testCount++;
        if (observed != expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic setAcc(input int j, input int v);
        acc_in_packed[j*20 +: 20] = v[19:0];
    endtask

    function automatic int qModel(input int a);
        int r;
        if (a < 0) return 0;
        r = a / 256;
        return (r > 127) ? 127 : r;
    endfunction

    task automatic applyStimulus();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic scrambleAcc();
        for (int j = 0; j < 32; j++) setAcc(j, int'($urandom_range(0, 1048575)) - 524288);
    endtask

    // Called at the negedge where the first beat should be visible.
    task automatic collectVector(input bit randReady, input bit scramble, input bit startInDone);
        int       count = 0;
        int       cycles = 0;
        bit       held = 1'b0;
        bit       rdy;
        int       hData = 0;
        int       hIdx = 0;
        while (count < 32 && cycles < 400) begin
            if (held) begin
                checkOutput("holdValid", out_valid, 1);
                checkOutput("holdData", out_data, hData);
                checkOutput("holdIdx", out_idx, hIdx);
            end
            rdy = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
            out_ready = rdy;
            if (scramble) begin
                scrambleAcc();
                start = (cycles == 12);
            end
            if (out_valid && rdy) begin
                checkOutput($sformatf("beatData%0d", count), out_data, expData[count]);
                checkOutput($sformatf("beatIdx%0d", count), out_idx, count);
                checkOutput($sformatf("beatLast%0d", count), out_last, (count == 31) ? 1 : 0);
                count++;
                held = 1'b0;
            end else begin
                held  = out_valid;
                hData = out_data;
                hIdx  = out_idx;
            end
            @(negedge clk);
            cycles++;
        end
        start = 1'b0;
        if (count < 32) checkOutput("beatTimeout", count, 32);
        checkOutput("doneHigh", done, 1);
        checkOutput("validAfterLast", out_valid, 0);
        checkOutput("busyInDone", busy, 1);
        out_ready = 1'b0;
        if (startInDone) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("doneLow", done, 0);
        checkOutput("idleBusy", busy, 0);
    endtask

    int sweepIn  [8] = '{0, 255, 256, 3200, -5000, 40000, 32767, -1};
    int sweepExp [8] = '{0, 0, 1, 12, 0, 127, 127, 0};

    initial begin
        int  waitCycles;
        bit  sawDone;

        rst = 1'b1;
        #12;
        checkOutput("rstValid", out_valid, 0);
        checkOutput("rstData", out_data, 0);
        checkOutput("rstIdx", out_idx, 0);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstDone", done, 0);
        @(negedge clk);
        rst = 1'b0;

        // Quantisation sweep on neuron 0.
        for (int s = 0; s < 8; s++) begin
            acc_in_packed = '0;
            setAcc(0, sweepIn[s]);
            for (int j = 0; j < 32; j++) expData[j] = 0;
            expData[0] = sweepExp[s];
            applyStimulus();
            @(negedge clk);
            collectVector(1'b0, 1'b0, 1'b0);
        end

        // Full vector with latency check.
        for (int j = 0; j < 32; j++) begin
            setAcc(j, j * 256);
            expData[j] = j;
        end
        applyStimulus();
        checkOutput("latencyValid0", out_valid, 0);
        checkOutput("latencyBusy", busy, 1);
        @(negedge clk);
        checkOutput("latencyValid1", out_valid, 1);
        collectVector(1'b0, 1'b0, 1'b0);

        // Backpressure with mixed negative, mid-range and saturating values.
        for (int j = 0; j < 32; j++) begin
            setAcc(j, j * 1300 - 9000);
            expData[j] = qModel(j * 1300 - 9000);
        end
        applyStimulus();
        @(negedge clk);
        collectVector(1'b1, 1'b0, 1'b0);

        // Snapshot isolation: inputs churn and start pulses mid-stream and in DONE.
        for (int j = 0; j < 32; j++) begin
            setAcc(j, (31 - j) * 512 + 100);
            expData[j] = qModel((31 - j) * 512 + 100);
        end
        applyStimulus();
        scrambleAcc();
        @(negedge clk);
        collectVector(1'b0, 1'b1, 1'b1);

        // Reset mid-stream at beat 10.
        for (int j = 0; j < 32; j++) setAcc(j, 30000);
        applyStimulus();
        out_ready = 1'b1;
        waitCycles = 0;
        while (!(out_valid && out_idx == 5'd10) && waitCycles < 100) begin
            @(negedge clk);
            waitCycles++;
        end
        checkOutput("reachBeat10", out_idx, 10);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midRstValid", out_valid, 0);
        checkOutput("midRstData", out_data, 0);
        checkOutput("midRstIdx", out_idx, 0);
        checkOutput("midRstLast", out_last, 0);
        checkOutput("midRstBusy", busy, 0);
        checkOutput("midRstDone", done, 0);
        @(negedge clk);
        rst = 1'b0;
        sawDone = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (done || out_valid) sawDone = 1'b1;
        end
        checkOutput("noDoneAfterRst", sawDone, 0);

        for (int j = 0; j < 32; j++) begin
            setAcc(j, j * 256 + 255);
            expData[j] = j;
        end
        applyStimulus();
        @(negedge clk);
        collectVector(1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
